// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: two requester ports (CPU and host),
// the shared memory port, and arbiter status outputs.
// slave  = the arbiter side; master = the requesters/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              grant_host;
  logic              busy;
  logic [1:0]        dbg_state;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output grant_host, busy, dbg_state
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  grant_host, busy, dbg_state
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants the single shared memory port to the CPU or the
// host/loader, runs a fixed wait-state access, then returns a one-cycle ack
// followed by a dead TURN cycle.
// Build option: define MEM_ARB_RR_EN for round-robin conflict resolution;
// when undefined the CPU has fixed priority over the host.
module mem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input logic               CLK,
  input logic               Reset,
  mem_port_arbiter_if.slave bus
);

  // 0 behaves as 1; the 4-bit counter tops out at 15 access cycles.
  localparam int WAIT_EFF = (WAIT_CYCLES < 1)  ? 1  :
                            (WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_EFF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2,
    TURN   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic              we_lat;
  logic [ADDR_W-1:0] addr_lat;
  logic [DATA_W-1:0] wdata_lat;
  logic              grant_host_r;
  logic [DATA_W-1:0] cpu_rdata_r;
  logic [DATA_W-1:0] host_rdata_r;
  logic              req_any;
  logic              pick_host;

`ifdef MEM_ARB_RR_EN
  // 1 when the host received the most recent grant; reset value favours CPU.
  logic              last_host;
`endif

  assign req_any = bus.cpu_req | bus.host_req;

  // Choose the winner among the requests visible in IDLE.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    pick_host = bus.host_req & (~bus.cpu_req | ~last_host);
`else
    pick_host = bus.host_req & ~bus.cpu_req;
`endif
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state sequencing: IDLE -> ACCESS (WAIT cycles) -> ACK -> TURN -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_any) state_next = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_next = ACK;
      ACK:     state_next = TURN;
      TURN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant latching, wait counting and read-data capture.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      cnt          <= '0;
      we_lat       <= 1'b0;
      addr_lat     <= '0;
      wdata_lat    <= '0;
      grant_host_r <= 1'b0;
      cpu_rdata_r  <= '0;
      host_rdata_r <= '0;
`ifdef MEM_ARB_RR_EN
      last_host    <= 1'b1;
`endif
    end else begin
      if (state == IDLE && req_any) begin
        we_lat       <= pick_host ? bus.host_we    : bus.cpu_we;
        addr_lat     <= pick_host ? bus.host_addr  : bus.cpu_addr;
        wdata_lat    <= pick_host ? bus.host_wdata : bus.cpu_wdata;
        grant_host_r <= pick_host;
        cnt          <= CNT_LOAD;
`ifdef MEM_ARB_RR_EN
        last_host    <= pick_host;
`endif
      end else if (state == ACCESS) begin
        if (cnt == 4'd0) begin
          // Writes leave both rdata registers untouched.
          if (!we_lat) begin
            if (grant_host_r) host_rdata_r <= bus.mem_rdata;
            else              cpu_rdata_r  <= bus.mem_rdata;
          end
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  // Strobes are decoded from state so a reset edge drops them immediately.
  assign bus.mem_en     = (state == ACCESS);
  assign bus.mem_we     = (state == ACCESS) & we_lat;
  assign bus.mem_addr   = addr_lat;
  assign bus.mem_wdata  = wdata_lat;
  assign bus.cpu_ack    = (state == ACK) & ~grant_host_r;
  assign bus.host_ack   = (state == ACK) &  grant_host_r;
  assign bus.cpu_rdata  = cpu_rdata_r;
  assign bus.host_rdata = host_rdata_r;
  assign bus.grant_host = grant_host_r;
  assign bus.busy       = (state != IDLE);
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (WAIT_CYCLES=2).
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int W  = 2;

  logic CLK = 1'b0;
  logic Reset = 1'b0;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  // Memory macro stand-in: 256 words indexed by addr[7:0], preset contents.
  logic [15:0] mem_arr [256];
  bit          written [256];

  function automatic logic [15:0] init_val(input logic [7:0] a);
    if (a == 8'h40) return 16'hBEEF;
    return {a, ~a} ^ 16'h3C3C;
  endfunction

  always @(posedge CLK) begin
    if (bus.mem_en && bus.mem_we) begin
      mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
      written[bus.mem_addr[7:0]] <= 1'b1;
    end
  end

  always_comb begin
    bus.mem_rdata = written[bus.mem_addr[7:0]] ? mem_arr[bus.mem_addr[7:0]]
                                               : init_val(bus.mem_addr[7:0]);
  end

  // Reference model state.
  logic [15:0] model_mem [256];
  logic [15:0] exp_cpu_rd;
  logic [15:0] exp_host_rd;
  bit          model_last_host;
  int          total = 0;
  int          bad = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ack(input int limit, output int n, output bit got_c, output bit got_h);
    n = 0; got_c = 1'b0; got_h = 1'b0;
    while (n < limit) begin
      tick();
      n++;
      if (bus.cpu_ack || bus.host_ack) begin
        got_c = bus.cpu_ack;
        got_h = bus.host_ack;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'h0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = 16'h0; bus.host_wdata = 16'h0;
    tick(); tick();
    total++;
    if ({bus.cpu_ack, bus.host_ack, bus.mem_en, bus.mem_we, bus.grant_host, bus.busy} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=000000",
        {bus.cpu_ack, bus.host_ack, bus.mem_en, bus.mem_we, bus.grant_host, bus.busy});
    end
    total++;
    if ({bus.cpu_rdata, bus.host_rdata} !== 32'h0) begin
      bad++; $display("FAIL reset_rdata got=%h want=0", {bus.cpu_rdata, bus.host_rdata});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata} !== 32'h0) begin
      bad++; $display("FAIL reset_membus got=%h want=0", {bus.mem_addr, bus.mem_wdata});
    end
    total++;
    if (bus.dbg_state !== 2'd0) begin
      bad++; $display("FAIL reset_state got=%0d want=0", bus.dbg_state);
    end
    exp_cpu_rd = 16'h0; exp_host_rd = 16'h0; model_last_host = 1'b1;
    Reset = 1'b1;
    tick();
    total++;
    if ({bus.dbg_state, bus.grant_host} !== {2'd1, 1'b0}) begin
      bad++; $display("FAIL reset_release_grant got=%0d/%b want=1/0", bus.dbg_state, bus.grant_host);
    end
    begin
      int n; bit gc, gh;
      wait_ack(W + 3, n, gc, gh);
      total++;
      if ({gc, gh, n} !== {1'b1, 1'b0, W}) begin
        bad++; $display("FAIL reset_first_ack got=c%b h%b n%0d want=c1 h0 n%0d", gc, gh, n, W);
      end
    end
    exp_cpu_rd = model_mem[8'h10]; model_last_host = 1'b0;
    total++;
    if (bus.cpu_rdata !== exp_cpu_rd) begin
      bad++; $display("FAIL reset_first_rdata got=%h want=%h", bus.cpu_rdata, exp_cpu_rd);
    end
    bus.cpu_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_cpu_read();
    int en_cnt = 0;
    int ack_early = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0040;
    for (int i = 0; i < W; i++) begin
      tick();
      if (bus.mem_en) en_cnt++;
      if (bus.cpu_ack || bus.host_ack) ack_early++;
    end
    tick();
    total++;
    if ({en_cnt, ack_early} !== {W, 0}) begin
      bad++; $display("FAIL cpu_read_access en=%0d early_acks=%0d want en=%0d early=0", en_cnt, ack_early, W);
    end
    total++;
    if ({bus.cpu_ack, bus.host_ack} !== 2'b10) begin
      bad++; $display("FAIL cpu_read_ack got=%b want=10", {bus.cpu_ack, bus.host_ack});
    end
    exp_cpu_rd = model_mem[8'h40]; model_last_host = 1'b0;
    total++;
    if (bus.cpu_rdata !== exp_cpu_rd) begin
      bad++; $display("FAIL cpu_read_data got=%h want=%h", bus.cpu_rdata, exp_cpu_rd);
    end
    total++;
    if (bus.host_rdata !== exp_host_rd) begin
      bad++; $display("FAIL cpu_read_host_untouched got=%h want=%h", bus.host_rdata, exp_host_rd);
    end
    bus.cpu_req = 1'b0;
    tick();
    total++;
    if (bus.cpu_ack !== 1'b0) begin
      bad++; $display("FAIL cpu_read_ack_width got=%b want=0", bus.cpu_ack);
    end
    tick();
  endtask

  task automatic test_host_write();
    int good_cyc = 0;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 16'h0100; bus.host_wdata = 16'h1234;
    for (int i = 0; i < W; i++) begin
      tick();
      if (bus.mem_en && bus.mem_we && bus.mem_addr == 16'h0100 && bus.mem_wdata == 16'h1234 && bus.grant_host)
        good_cyc++;
    end
    total++;
    if (good_cyc !== W) begin
      bad++; $display("FAIL host_write_strobes got=%0d cycles want=%0d", good_cyc, W);
    end
    tick();
    total++;
    if ({bus.cpu_ack, bus.host_ack, bus.mem_en, bus.mem_we} !== 4'b0100) begin
      bad++; $display("FAIL host_write_ack got=%b want=0100", {bus.cpu_ack, bus.host_ack, bus.mem_en, bus.mem_we});
    end
    model_mem[8'h00] = 16'h1234; model_last_host = 1'b1;
    total++;
    if ({bus.cpu_rdata, bus.host_rdata} !== {exp_cpu_rd, exp_host_rd}) begin
      bad++; $display("FAIL host_write_rdata got=%h/%h want=%h/%h", bus.cpu_rdata, bus.host_rdata, exp_cpu_rd, exp_host_rd);
    end
    bus.host_req = 1'b0; bus.host_we = 1'b0;
    tick();
    total++;
    if (bus.host_ack !== 1'b0) begin
      bad++; $display("FAIL host_write_ack_width got=%b want=0", bus.host_ack);
    end
    tick();
  endtask

  task automatic test_conflict();
    int n; bit gc, gh; bit exp_h;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0020;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'h0030;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_h = ~model_last_host;
`else
      exp_h = 1'b0;
`endif
      wait_ack(W + 5, n, gc, gh);
      total++;
      if ({gc, gh} !== {~exp_h, exp_h} || n != ((k == 0) ? W + 1 : W + 3)) begin
        bad++; $display("FAIL conflict_grant%0d got=c%b h%b n%0d want=c%b h%b n%0d",
          k, gc, gh, n, ~exp_h, exp_h, (k == 0) ? W + 1 : W + 3);
      end
      if (exp_h) exp_host_rd = model_mem[8'h30];
      else       exp_cpu_rd  = model_mem[8'h20];
      model_last_host = exp_h;
    end
`ifndef MEM_ARB_RR_EN
    bus.cpu_req = 1'b0;
    wait_ack(W + 5, n, gc, gh);
    total++;
    if ({gc, gh, n} !== {1'b0, 1'b1, W + 3}) begin
      bad++; $display("FAIL conflict_host_after_drop got=c%b h%b n%0d want=c0 h1 n%0d", gc, gh, n, W + 3);
    end
    exp_host_rd = model_mem[8'h30]; model_last_host = 1'b1;
`endif
    total++;
    if ({bus.cpu_rdata, bus.host_rdata} !== {exp_cpu_rd, exp_host_rd}) begin
      bad++; $display("FAIL conflict_rdata got=%h/%h want=%h/%h", bus.cpu_rdata, bus.host_rdata, exp_cpu_rd, exp_host_rd);
    end
    bus.cpu_req = 1'b0; bus.host_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_write();
    int acks = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h00FF; bus.cpu_wdata = 16'hAAAA;
    tick(); tick();
    total++;
    if ({bus.mem_en, bus.mem_we} !== 2'b11) begin
      bad++; $display("FAIL midreset_pre got=%b want=11", {bus.mem_en, bus.mem_we});
    end
    Reset = 1'b0;
    tick();
    total++;
    if ({bus.mem_we, bus.busy, bus.dbg_state} !== 4'b0) begin
      bad++; $display("FAIL midreset_abort got=%b want=0000", {bus.mem_we, bus.busy, bus.dbg_state});
    end
    Reset = 1'b1; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    exp_cpu_rd = 16'h0; exp_host_rd = 16'h0; model_last_host = 1'b1;
    for (int i = 0; i < 2 * W + 4; i++) begin
      tick();
      if (bus.cpu_ack || bus.host_ack) acks++;
    end
    total++;
    if (acks !== 0) begin
      bad++; $display("FAIL midreset_no_ack got=%0d acks want=0", acks);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit gc, gh;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0100;
    wait_ack(W + 3, n, gc, gh);
    exp_cpu_rd = model_mem[8'h00];
    total++;
    if ({gc, gh, n, bus.cpu_rdata} !== {1'b1, 1'b0, W + 1, exp_cpu_rd}) begin
      bad++; $display("FAIL b2b_first got=c%b h%b n%0d d%h want=c1 h0 n%0d d%h", gc, gh, n, bus.cpu_rdata, W + 1, exp_cpu_rd);
    end
    bus.cpu_addr = 16'h0040;
    tick();
    total++;
    if (bus.mem_en !== 1'b0) begin
      bad++; $display("FAIL b2b_turn_idle got=%b want=0", bus.mem_en);
    end
    tick();
    total++;
    if (bus.mem_en !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got=%b want=0", bus.mem_en);
    end
    tick();
    total++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 16'h0040}) begin
      bad++; $display("FAIL b2b_second_start got=%b/%h want=1/0040", bus.mem_en, bus.mem_addr);
    end
    wait_ack(W + 3, n, gc, gh);
    exp_cpu_rd = model_mem[8'h40]; model_last_host = 1'b0;
    total++;
    if ({gc, n, bus.cpu_rdata} !== {1'b1, W, exp_cpu_rd}) begin
      bad++; $display("FAIL b2b_second got=c%b n%0d d%h want=c1 n%0d d%h", gc, n, bus.cpu_rdata, W, exp_cpu_rd);
    end
    bus.cpu_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random();
    bit pend_c = 1'b0, pend_h = 1'b0, first = 1'b1;
    bit win_h, gc, gh;
    int n;
    for (int r = 0; r < 40; r++) begin
      if (!pend_c && $urandom_range(0, 1) == 1) begin
        bus.cpu_we = 1'($urandom_range(0, 1));
        bus.cpu_addr = {8'($urandom), 2'b00, 6'($urandom)};
        bus.cpu_wdata = 16'($urandom);
        bus.cpu_req = 1'b1; pend_c = 1'b1;
      end
      if (!pend_h && $urandom_range(0, 1) == 1) begin
        bus.host_we = 1'($urandom_range(0, 1));
        bus.host_addr = {8'($urandom), 2'b00, 6'($urandom)};
        bus.host_wdata = 16'($urandom);
        bus.host_req = 1'b1; pend_h = 1'b1;
      end
      if (!pend_c && !pend_h) begin
        bus.cpu_we = 1'($urandom_range(0, 1));
        bus.cpu_addr = {8'($urandom), 2'b00, 6'($urandom)};
        bus.cpu_wdata = 16'($urandom);
        bus.cpu_req = 1'b1; pend_c = 1'b1;
      end
      if (pend_c && pend_h) begin
`ifdef MEM_ARB_RR_EN
        win_h = ~model_last_host;
`else
        win_h = 1'b0;
`endif
      end else begin
        win_h = pend_h;
      end
      wait_ack(W + 5, n, gc, gh);
      total++;
      if ({gc, gh} !== {~win_h, win_h} || n != (first ? W + 1 : W + 3)) begin
        bad++; $display("FAIL rand%0d_grant got=c%b h%b n%0d want=c%b h%b n%0d",
          r, gc, gh, n, ~win_h, win_h, first ? W + 1 : W + 3);
      end
      if (win_h) begin
        if (bus.host_we) model_mem[bus.host_addr[7:0]] = bus.host_wdata;
        else             exp_host_rd = model_mem[bus.host_addr[7:0]];
        bus.host_req = 1'b0; pend_h = 1'b0;
      end else begin
        if (bus.cpu_we) model_mem[bus.cpu_addr[7:0]] = bus.cpu_wdata;
        else            exp_cpu_rd = model_mem[bus.cpu_addr[7:0]];
        bus.cpu_req = 1'b0; pend_c = 1'b0;
      end
      model_last_host = win_h;
      total++;
      if ({bus.cpu_rdata, bus.host_rdata} !== {exp_cpu_rd, exp_host_rd}) begin
        bad++; $display("FAIL rand%0d_rdata got=%h/%h want=%h/%h", r, bus.cpu_rdata, bus.host_rdata, exp_cpu_rd, exp_host_rd);
      end
      first = 1'b0;
    end
    bus.cpu_req = 1'b0; bus.host_req = 1'b0;
    tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(8'(i));
    test_reset();
    test_cpu_read();
    test_host_write();
    test_conflict();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
